// File: rtl/messbauer_spectrum_accumulator_if.sv
// ---------------------------------------------------------------------------
// messbauer_spectrum_accumulator_if
//
// This interface groups the acquisition inputs, the control inputs, the
// spectrum read port and the status outputs of the Mossbauer spectrum
// accumulator. The clock and the reset are kept outside the interface.
//
// Signals:
//   start, channel                    sweep generator pulses
//   lower_threshold, upper_threshold  discriminator pulses
//   clear                             request to zero the spectrum and the counters
//   rd_en, rd_addr                    read request for the spectrum memory
//   rd_data, rd_valid                 registered read result
//   current_channel, sweep_count      live sweep position and sweep counter
//   busy, saturated, overrun          status flags
//
// Modports:
//   master : the environment side, which drives the requests and samples the status
//   slave  : the accumulator side
// ---------------------------------------------------------------------------
interface messbauer_spectrum_accumulator_if #(
  parameter int ADDR_WIDTH    = 9,
  parameter int COUNTER_WIDTH = 16
);
  logic                     start;
  logic                     channel;
  logic                     lower_threshold;
  logic                     upper_threshold;
  logic                     clear;
  logic                     rd_en;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [COUNTER_WIDTH-1:0] rd_data;
  logic                     rd_valid;
  logic [ADDR_WIDTH-1:0]    current_channel;
  logic [15:0]              sweep_count;
  logic                     busy;
  logic                     saturated;
  logic                     overrun;

  modport master (
    output start, channel, lower_threshold, upper_threshold, clear, rd_en, rd_addr,
    input  rd_data, rd_valid, current_channel, sweep_count, busy, saturated, overrun
  );

  modport slave (
    input  start, channel, lower_threshold, upper_threshold, clear, rd_en, rd_addr,
    output rd_data, rd_valid, current_channel, sweep_count, busy, saturated, overrun
  );
endinterface

// File: rtl/messbauer_spectrum_accumulator.sv
// ---------------------------------------------------------------------------
// messbauer_spectrum_accumulator
//
// This module builds a Mossbauer velocity spectrum. The start and channel
// pulses from the sweep generator track the current velocity channel.
// Discriminator pulses are qualified in a coincidence window:
//   - a lower pulse without an upper pulse counts as an event;
//   - each accepted event increments the count of its channel.
// The counts are stored in a dual-port memory:
//   - port A does the read-modify-write for accumulation and the clear writes;
//   - port B is a registered readout port.
//
// Ports:
//   aclk      system clock
//   areset_n  asynchronous active-low reset (enters the automatic clear)
//   bus       messbauer_spectrum_accumulator_if.slave
//     inputs : start, channel, lower_threshold, upper_threshold, clear,
//              rd_en, rd_addr
//     outputs: rd_data, rd_valid, current_channel, sweep_count, busy,
//              saturated, overrun
//
// Optional feature (macro MESSBAUER_INPUT_SYNC_EN):
//   - Defined: the four acquisition inputs each pass through a 2-flop
//     synchronizer before edge detection. This allows pin-level
//     asynchronous inputs and adds 2 cycles to every input latency.
//   - Undefined: the acquisition inputs must be synchronous to aclk.
// ---------------------------------------------------------------------------
module messbauer_spectrum_accumulator #(
  parameter int CHANNEL_NUMBER = 512,
  parameter int ADDR_WIDTH     = 9,
  parameter int COUNTER_WIDTH  = 16,
  parameter int WINDOW         = 8
) (
  input logic                          aclk,
  input logic                          areset_n,
  messbauer_spectrum_accumulator_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0]    LAST_CH  = ADDR_WIDTH'(CHANNEL_NUMBER - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam int                       WIN_W    = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0]         WIN_LOAD = WIN_W'(WINDOW);
  localparam logic [WIN_W-1:0]         WIN_LAST = WIN_W'(1);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_ACQUIRE = 2'd2
  } state_t;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc_cnt(input logic [COUNTER_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc_sweep(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Input conditioning
  logic w_start_in, w_channel_in, w_lower_in, w_upper_in;

`ifdef MESSBAUER_INPUT_SYNC_EN
  logic [3:0] r_sync_meta;
  logic [3:0] r_sync_q;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_sync_meta <= '0;
      r_sync_q    <= '0;
    end else begin
      r_sync_meta <= {bus.start, bus.channel, bus.lower_threshold, bus.upper_threshold};
      r_sync_q    <= r_sync_meta;
    end
  end

  assign {w_start_in, w_channel_in, w_lower_in, w_upper_in} = r_sync_q;
`else
  assign {w_start_in, w_channel_in, w_lower_in, w_upper_in} =
    {bus.start, bus.channel, bus.lower_threshold, bus.upper_threshold};
`endif

  // Rising-edge detection: the edge is seen in the cycle when the input is
  // first sampled high. It acts on the registers at that clock edge.
  logic [4:0] r_in_d;
  logic [4:0] w_in;
  logic [4:0] w_edge;
  logic       w_start_edge, w_channel_edge, w_lower_edge, w_upper_edge, w_clear_edge;

  assign w_in   = {w_start_in, w_channel_in, w_lower_in, w_upper_in, bus.clear};
  assign w_edge = w_in & ~r_in_d;
  assign {w_start_edge, w_channel_edge, w_lower_edge, w_upper_edge, w_clear_edge} = w_edge;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_in_d <= '0;
    else           r_in_d <= w_in;
  end

  // Control state
  state_t                   r_state;
  logic [ADDR_WIDTH-1:0]    r_clr_addr;
  logic                     r_busy;
  logic [ADDR_WIDTH-1:0]    r_cur_ch;
  logic [15:0]              r_sweep;
  logic                     r_sat;
  logic                     r_ovr;
  logic                     r_win_open;
  logic [WIN_W-1:0]         r_win_cnt;
  logic                     r_win_rej;
  logic                     r_acc_vld_p0;
  logic                     r_vld_p1;

  // Data path
  logic [COUNTER_WIDTH-1:0] r_mem [CHANNEL_NUMBER];
  logic [ADDR_WIDTH-1:0]    r_evt_addr;
  logic [ADDR_WIDTH-1:0]    r_acc_addr_p0;
  logic [ADDR_WIDTH-1:0]    r_addr_p1;
  logic [COUNTER_WIDTH-1:0] r_old_p1;
  logic [COUNTER_WIDTH-1:0] w_new_p1;

  logic                     w_open_evt;
  logic                     w_wr_en;
  logic [ADDR_WIDTH-1:0]    w_wr_addr;
  logic [COUNTER_WIDTH-1:0] w_wr_data;

  assign w_open_evt = (r_state == S_ACQUIRE) && !r_win_open && w_lower_edge;
  assign w_new_p1   = sat_inc_cnt(r_old_p1);

  // Port A: clear writes take priority. The RMW pipeline is flushed whenever
  // the clear starts.
  assign w_wr_en   = (r_state == S_CLEAR) || r_vld_p1;
  assign w_wr_addr = (r_state == S_CLEAR) ? r_clr_addr : r_addr_p1;
  assign w_wr_data = (r_state == S_CLEAR) ? '0 : w_new_p1;

  // ---- p0: accept -> p1: read old count -> write incremented count ----
  always_ff @(posedge aclk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
    if (w_open_evt) r_evt_addr <= r_cur_ch;
    r_acc_addr_p0 <= r_evt_addr;
    r_addr_p1     <= r_acc_addr_p0;
    // A write in flight to the same address has not landed yet. Take its
    // value so that back-to-back accepts do not lose a count.
    if (r_vld_p1 && (r_addr_p1 == r_acc_addr_p0)) r_old_p1 <= w_new_p1;
    else                                          r_old_p1 <= r_mem[r_acc_addr_p0];
  end

  // Control FSM with registered status outputs
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= S_CLEAR;
      r_clr_addr   <= '0;
      r_busy       <= 1'b1;
      r_cur_ch     <= '0;
      r_sweep      <= '0;
      r_sat        <= 1'b0;
      r_ovr        <= 1'b0;
      r_win_open   <= 1'b0;
      r_win_cnt    <= '0;
      r_win_rej    <= 1'b0;
      r_acc_vld_p0 <= 1'b0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_acc_vld_p0 <= 1'b0;
      r_vld_p1     <= r_acc_vld_p0;
      if (r_vld_p1 && (w_new_p1 == CNT_MAX)) r_sat <= 1'b1;

      case (r_state)
        S_CLEAR: begin
          r_cur_ch   <= '0;
          r_sweep    <= '0;
          r_sat      <= 1'b0;
          r_ovr      <= 1'b0;
          r_win_open <= 1'b0;
          r_win_rej  <= 1'b0;
          r_vld_p1   <= 1'b0;
          if (w_clear_edge) begin
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
          end else if (r_clr_addr == LAST_CH) begin
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end

        S_IDLE: begin
          if (w_clear_edge) begin
            r_state    <= S_CLEAR;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
          end else if (w_start_edge) begin
            r_state  <= S_ACQUIRE;
            r_cur_ch <= '0;
            r_sweep  <= 16'd1;
          end
        end

        S_ACQUIRE: begin
          if (w_clear_edge) begin
            r_state      <= S_CLEAR;
            r_busy       <= 1'b1;
            r_clr_addr   <= '0;
            r_win_open   <= 1'b0;
            r_acc_vld_p0 <= 1'b0;
            r_vld_p1     <= 1'b0;
          end else begin
            // When start and channel edges arrive together, start wins.
            if (w_start_edge) begin
              r_cur_ch <= '0;
              r_sweep  <= sat_inc_sweep(r_sweep);
            end else if (w_channel_edge) begin
              if (r_cur_ch == LAST_CH) r_ovr    <= 1'b1;
              else                     r_cur_ch <= r_cur_ch + 1'b1;
            end

            // Coincidence window. A lower edge while the window is open is
            // ignored (dead time).
            if (!r_win_open) begin
              if (w_lower_edge) begin
                r_win_open <= 1'b1;
                r_win_cnt  <= WIN_LOAD;
                r_win_rej  <= w_upper_edge;
              end
            end else begin
              if (w_upper_edge) r_win_rej <= 1'b1;
              if (r_win_cnt == WIN_LAST) begin
                r_win_open   <= 1'b0;
                r_acc_vld_p0 <= !(r_win_rej || w_upper_edge);
              end else begin
                r_win_cnt <= r_win_cnt - 1'b1;
              end
            end
          end
        end

        default: begin
          r_state    <= S_CLEAR;
          r_busy     <= 1'b1;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

  // Port B readout. A read during a write to the same address returns the
  // old value. Reads return 0 while the clear is running.
  logic [COUNTER_WIDTH-1:0] r_rd_data;
  logic                     r_rd_valid;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= (r_state == S_CLEAR) ? '0 : r_mem[bus.rd_addr];
    end
  end

  assign bus.rd_data         = r_rd_data;
  assign bus.rd_valid        = r_rd_valid;
  assign bus.current_channel = r_cur_ch;
  assign bus.sweep_count     = r_sweep;
  assign bus.busy            = r_busy;
  assign bus.saturated       = r_sat;
  assign bus.overrun         = r_ovr;

endmodule
